// File: rtl/change_dispenser.sv
// Coin-return engine: pays a cent amount out as timed eject pulses to five hoppers,
// largest coin first, skipping empty hoppers and reporting any unpaid remainder.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] amount,
  input  logic       emptyDollar,
  input  logic       emptyFifty,
  input  logic       emptyQuarter,
  input  logic       emptyDime,
  input  logic       emptyNickel,
  output logic       ejectDollar,
  output logic       ejectFifty,
  output logic       ejectQuarter,
  output logic       ejectDime,
  output logic       ejectNickel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] remaining,
  output logic [5:0] coinsOut
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE, S_FAULT
  } state_t;

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  // Index 4 is the dollar hopper, index 0 the nickel hopper.
  function automatic logic [8:0] coin_value(input int idx);
    case (idx)
      4:       coin_value = 9'd100;
      3:       coin_value = 9'd50;
      2:       coin_value = 9'd25;
      1:       coin_value = 9'd10;
      default: coin_value = 9'd5;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [8:0]       rem_q, rem_d;
  logic [5:0]       coins_q, coins_d;
  logic             err_q, err_d;
  logic [4:0]       eject_q, eject_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] empty_vec;
  logic       pick_ok;
  logic [4:0] pick_onehot;
  logic [8:0] pick_val;
  logic       amount_bad;

  assign empty_vec  = {emptyDollar, emptyFifty, emptyQuarter, emptyDime, emptyNickel};
  assign amount_bad = (amount > 9'd500) || ((amount % 9'd5) != 9'd0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick_ok     = 1'b0;
    pick_onehot = '0;
    pick_val    = '0;
    for (int i = 4; i >= 0; i--) begin
      if (!pick_ok && !empty_vec[i] && (coin_value(i) <= rem_q)) begin
        pick_ok        = 1'b1;
        pick_onehot[i] = 1'b1;
        pick_val       = coin_value(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coins_d = coins_q;
    err_d   = err_q;
    eject_d = eject_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = amount;
          coins_d = '0;
          err_d   = amount_bad;
          state_d = amount_bad ? S_FAULT : S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 9'd0) begin
          state_d = S_DONE;
        end else if (pick_ok) begin
          rem_d   = rem_q - pick_val;
          coins_d = (coins_q == 6'd63) ? coins_q : coins_q + 6'd1;
          eject_d = pick_onehot;
          cnt_d   = PULSE_LAST;
          state_d = S_EJECT;
        end else begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_EJECT: begin
        if (cnt_q == '0) begin
          eject_d = '0;
          cnt_d   = GAP_LAST;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_SELECT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      coins_q <= '0;
      err_q   <= 1'b0;
      eject_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coins_q <= coins_d;
      err_q   <= err_d;
      eject_q <= eject_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {ejectDollar, ejectFifty, ejectQuarter, ejectDime, ejectNickel} = eject_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) || (state_q == S_FAULT);
  assign error     = err_q;
  assign remaining = rem_q;
  assign coinsOut  = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random payouts
// compared cycle by cycle against a greedy-payout reference model.
module tb_change_dispenser;

  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 1 + P + G;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] amount;
  logic [4:0] empt;
  logic       ej_dollar, ej_fifty, ej_quarter, ej_dime, ej_nickel;
  logic       busy, done, error;
  logic [8:0] remaining;
  logic [5:0] coins_out;

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount),
    .emptyDollar(empt[4]), .emptyFifty(empt[3]), .emptyQuarter(empt[2]),
    .emptyDime(empt[1]), .emptyNickel(empt[0]),
    .ejectDollar(ej_dollar), .ejectFifty(ej_fifty), .ejectQuarter(ej_quarter),
    .ejectDime(ej_dime), .ejectNickel(ej_nickel),
    .busy(busy), .done(done), .error(error),
    .remaining(remaining), .coinsOut(coins_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int eject_vec();
    return int'({ej_dollar, ej_fifty, ej_quarter, ej_dime, ej_nickel});
  endfunction

  // Reference model: greedy payout over the coin values, skipping empty hoppers.
  int vals[5] = '{5, 10, 25, 50, 100};
  int exp_coins[$];
  int exp_rem, exp_err, exp_done_cyc;

  task automatic model(input int amt, input logic [4:0] e);
    int rem;
    int found;
    exp_coins.delete();
    exp_err = 0;
    rem = amt;
    if (amt > 500 || (amt % 5) != 0) begin
      exp_err = 1;
      exp_done_cyc = 1;
    end else begin
      while (rem > 0) begin
        found = -1;
        for (int i = 4; i >= 0; i--)
          if (found < 0 && !e[i] && vals[i] <= rem) found = i;
        if (found < 0) begin
          exp_err = 1;
          break;
        end
        exp_coins.push_back(found);
        rem -= vals[found];
      end
      exp_done_cyc = 2 + exp_coins.size() * T;
    end
    exp_rem = rem;
  endtask

  function automatic int exp_eject(input int c);
    int k, off;
    if (exp_done_cyc == 1 || c < 2 || c >= exp_done_cyc) return 0;
    k   = (c - 1) / T;
    off = (c - 1) % T;
    if (off >= 1 && off <= P && k < exp_coins.size()) return 1 << exp_coins[k];
    return 0;
  endfunction

  // Entered at a negedge during an IDLE cycle; leaves at the negedge of the first
  // IDLE cycle after done. restart_cyc >= 2 pulses start while busy.
  task automatic run_txn(input int amt, input logic [4:0] e, input int restart_cyc);
    int d, ncoins;
    model(amt, e);
    d = exp_done_cyc;
    ncoins = (exp_coins.size() > 63) ? 63 : exp_coins.size();
    amount = 9'(amt);
    empt   = e;
    start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      check($sformatf("eject amt=%0d c=%0d", amt, c), eject_vec(), exp_eject(c));
      check($sformatf("done amt=%0d c=%0d", amt, c), int'(done), (c == d) ? 1 : 0);
      check($sformatf("busy amt=%0d c=%0d", amt, c), int'(busy), (c <= d) ? 1 : 0);
      check($sformatf("error amt=%0d c=%0d", amt, c), int'(error), (c >= d) ? exp_err : 0);
      if (c == 1)
        check($sformatf("rem_latch amt=%0d", amt), int'(remaining),
              (d == 1) ? amt : ((exp_coins.size() == 0) ? amt : amt));
      if (c >= d) begin
        check($sformatf("remaining amt=%0d c=%0d", amt, c), int'(remaining), exp_rem);
        check($sformatf("coinsOut amt=%0d c=%0d", amt, c), int'(coins_out), ncoins);
      end
      if (restart_cyc >= 2 && c == restart_cyc) begin
        start  = 1'b1;
        amount = 9'd5;
      end else if (restart_cyc >= 2 && c == restart_cyc + 1) begin
        start  = 1'b0;
        amount = 9'(amt);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " eject"}, eject_vec(), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " error"}, int'(error), 0);
    check({tag, " remaining"}, int'(remaining), 0);
    check({tag, " coinsOut"}, int'(coins_out), 0);
  endtask

  initial begin
    int amt;
    logic [4:0] e;
    rst_n  = 1'b0;
    start  = 1'b0;
    amount = '0;
    empt   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(65, 5'b00000, -1);
    run_txn(500, 5'b10000, -1);
    run_txn(30, 5'b00101, -1);
    run_txn(5, 5'b00001, -1);
    run_txn(505, 5'b00000, -1);
    run_txn(7, 5'b00000, -1);
    run_txn(0, 5'b00000, -1);
    run_txn(100, 5'b00000, 3);
    run_txn(15, 5'b00000, -1);
    run_txn(500, 5'b11110, -1);

    // Reset in the second EJECT cycle of a 75-cent payout.
    amount = 9'd75;
    empt   = '0;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_txn eject c2", eject_vec(), 5'b01000);
    @(negedge clk);
    check("rst_txn eject c3", eject_vec(), 5'b01000);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(25, 5'b00000, -1);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 7) == 0) amt = int'($urandom_range(0, 511));
      else                           amt = 5 * int'($urandom_range(0, 100));
      e = 5'($urandom_range(0, 31));
      run_txn(amt, e, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
